// File: rtl/ir_pkg.sv
// ir_pkg: shared encodings, NEC frame field positions and event record layout for the IR key controller.
package ir_pkg;
  typedef enum logic [1:0] {EVT_PRESS = 2'd0, EVT_REPEAT = 2'd1, EVT_RELEASE = 2'd2} evt_t;
  typedef enum logic [1:0] {IDLE, WAIT_RPT, AUTO_RPT, SWITCH} state_t;
  localparam int ADDR_LSB = 0;
  localparam int ADDRN_LSB = 8;
  localparam int CMD_LSB = 16;
  localparam int CMDN_LSB = 24;
  typedef struct packed {
    evt_t typ;
    logic [7:0] key;
  } evt_rec_t;
  localparam int EVT_W = $bits(evt_rec_t);
  function automatic int max3(int a, int b, int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/ir_evt_fifo.sv
// ir_evt_fifo: first-word-fall-through event FIFO; a push into a full FIFO is taken only alongside a pop.
module ir_evt_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     RSTN,
  input  logic                     push,
  input  logic                     pop,
  input  evt_rec_t                 din,
  output evt_rec_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  evt_rec_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge CLOCK_50 or negedge RSTN)
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge CLOCK_50)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/ir_key_ctrl.sv
// ir_key_ctrl: turns validated NEC frames and repeat codes into buffered PRESS/REPEAT/RELEASE key events.
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter int         RELEASE_TMO    = 6000000,
  parameter int         RPT_DELAY      = 25000000,
  parameter int         RPT_PERIOD     = 10000000,
  parameter int         FIFO_DEPTH     = 4,
  parameter bit         ADDR_FILTER_EN = 1'b0,
  parameter logic [7:0] ADDR           = 8'h00
) (
  input  logic        CLOCK_50,
  input  logic        RSTN,
  input  logic        frame_valid,
  input  logic [31:0] frame_data,
  input  logic        repeat_pulse,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [7:0]  evt_key,
  output logic        key_held,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic [7:0]  err_cnt
);
  localparam int TW = $clog2(max3(RELEASE_TMO, RPT_DELAY, RPT_PERIOD));
  localparam logic [TW-1:0] REL_LAST = TW'(RELEASE_TMO - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(RPT_PERIOD - 1);
  state_t state, state_n;
  logic [7:0] cur_key, cur_n, pend_key, pend_n, cmd, addr;
  logic [TW-1:0] rel_cnt, rel_n, rpt_cnt, rpt_n;
  logic good, good_frame, rpt_last, push, pop, full, empty, drop;
  evt_rec_t push_rec, head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic unused_ok;
  assign cmd        = frame_data[CMD_LSB +: 8];
  assign addr       = frame_data[ADDR_LSB +: 8];
  assign good       = (cmd == ~frame_data[CMDN_LSB +: 8]) && (!ADDR_FILTER_EN || addr == ADDR);
  assign good_frame = frame_valid && good;
  assign rpt_last   = rpt_cnt == (state == WAIT_RPT ? DLY_LAST : PER_LAST);
  assign key_held   = state == WAIT_RPT || state == AUTO_RPT;
  assign evt_valid  = !empty;
  assign pop        = evt_valid && evt_ready;
  assign drop       = push && full && !pop;
  assign evt_type   = head.typ;
  assign evt_key    = head.key;
  assign unused_ok  = ^{frame_data[ADDRN_LSB +: 8], fifo_count};
  always_comb begin
    state_n  = state;
    cur_n    = cur_key;
    pend_n   = pend_key;
    rel_n    = rel_cnt;
    rpt_n    = rpt_cnt;
    push     = 1'b0;
    push_rec = '0;
    case (state)
      IDLE:
        if (good_frame) begin
          push     = 1'b1;
          push_rec = '{EVT_PRESS, cmd};
          cur_n    = cmd;
          rel_n    = '0;
          rpt_n    = '0;
          state_n  = WAIT_RPT;
        end
      SWITCH: begin
        push     = 1'b1;
        push_rec = '{EVT_PRESS, pend_key};
        cur_n    = pend_key;
        rel_n    = '0;
        rpt_n    = '0;
        state_n  = WAIT_RPT;
      end
      default:
        if (good_frame && cmd != cur_key) begin
          push     = 1'b1;
          push_rec = '{EVT_RELEASE, cur_key};
          pend_n   = cmd;
          state_n  = SWITCH;
        end else begin
          rpt_n = rpt_last ? '0 : rpt_cnt + 1'b1;
          if (rpt_last) begin
            push     = 1'b1;
            push_rec = '{EVT_REPEAT, cur_key};
            state_n  = AUTO_RPT;
          end
          // a bad frame shadows a same-cycle repeat code, so only good frames or lone repeats refresh
          if (good_frame || (repeat_pulse && !frame_valid))
            rel_n = '0;
          else if (rel_cnt == REL_LAST) begin
            push     = 1'b1;
            push_rec = '{EVT_RELEASE, cur_key};
            state_n  = IDLE;
          end else
            rel_n = rel_cnt + 1'b1;
        end
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge RSTN)
    if (!RSTN) begin
      state    <= IDLE;
      cur_key  <= '0;
      pend_key <= '0;
      rel_cnt  <= '0;
      rpt_cnt  <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cur_key  <= cur_n;
      pend_key <= pend_n;
      rel_cnt  <= rel_n;
      rpt_cnt  <= rpt_n;
      err_cnt  <= (frame_valid && !good && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
      overflow <= drop || (overflow && !ovf_clr);
    end
  ir_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .RSTN     (RSTN),
    .push     (push),
    .pop      (pop),
    .din      (push_rec),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );
endmodule
